pbvi_step3: RTL

PBVI_STEP3 -- requirements
Module: pbvi_step3

---
 rtl/pbvi_step3.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pbvi_step3.sv
// PBVI backup step 3: per-belief argmax over action alpha candidates.
// Optional best_action output is enabled by defining PBVI_STEP3_POLICY_OUT_EN.
module pbvi_step3 #(
    parameter int unsigned N_BELIEF = 16,
    parameter int unsigned N_ACTION = 3,
    parameter int unsigned W        = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         en,
    input  logic [0:N_ACTION-1][0:N_BELIEF-1][0:1][W-1:0] gamma_action_belief,
    input  logic [0:N_BELIEF-1][0:1][W-1:0]              point_belief,
    output logic [0:N_BELIEF-1][0:1][W-1:0]              alpha_out,
    output logic [0:N_BELIEF-1][W:0]                     value_out,
`ifdef PBVI_STEP3_POLICY_OUT_EN
    output logic [0:N_BELIEF-1][1:0]                     best_action,
`endif
    output logic                                         busy,
    output logic                                         done
);

    localparam int unsigned IW = (N_BELIEF > 1) ? $clog2(N_BELIEF) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                                      state;
    logic [IW-1:0]                               idx;
    logic [0:N_ACTION-1][0:N_BELIEF-1][0:1][W-1:0] g_lat;
    logic [0:N_BELIEF-1][0:1][W-1:0]             b_lat;

    logic [2*W-1:0] p0;
    logic [2*W-1:0] p1;
    logic [2*W:0]   sum;
    logic [W:0]     win_val;
    logic [1:0]     win;
    logic [W-1:0]   win_g0;
    logic [W-1:0]   win_g1;

    // Strict '>' keeps the lowest action index on ties.
    always_comb begin
        p0      = '0;
        p1      = '0;
        sum     = '0;
        win_val = '0;
        win     = '0;
        win_g0  = '0;
        win_g1  = '0;
        for (int unsigned a = 0; a < N_ACTION; a++) begin
            p0  = {{W{1'b0}}, g_lat[a][idx][0]} * {{W{1'b0}}, b_lat[idx][0]};
            p1  = {{W{1'b0}}, g_lat[a][idx][1]} * {{W{1'b0}}, b_lat[idx][1]};
            sum = {1'b0, p0} + {1'b0, p1};
            if (a == 0 || sum[2*W:W] > win_val) begin
                win_val = sum[2*W:W];
                win     = 2'(a);
                win_g0  = g_lat[a][idx][0];
                win_g1  = g_lat[a][idx][1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            g_lat     <= '0;
            b_lat     <= '0;
            alpha_out <= '0;
            value_out <= '0;
`ifdef PBVI_STEP3_POLICY_OUT_EN
            best_action <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (en) begin
                // Restart from any state; an aborted run never reaches DONE.
                state <= CAPTURE;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    CAPTURE: begin
                        g_lat <= gamma_action_belief;
                        b_lat <= point_belief;
                        idx   <= '0;
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                    SCAN: begin
                        alpha_out[idx][0] <= win_g0;
                        alpha_out[idx][1] <= win_g1;
                        value_out[idx]    <= win_val;
`ifdef PBVI_STEP3_POLICY_OUT_EN
                        best_action[idx]  <= win;
`endif
                        if (idx == IW'(N_BELIEF - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx  <= idx + 1'b1;
                            busy <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
